// File: rtl/video_plex_mixer.sv
// video_plex_mixer
//   Pipelined pixel-plex mixer. It merges NUM_LAYERS layer pixel streams and a
//   border colour into one palette index for each pixel strobe. A runtime
//   priority list chooses the layer, and each layer can be gated by an enable
//   and by a window. In hi-res mode, two 4-bit pixels are packed into each
//   output byte. The block sits between the renderers and the palette lookup.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high (overrides c1)
//   c1          pixel strobe; every register advances only when c1=1
//   pix_valid   the current strobe carries a real pixel
//   layer_pix   layer i pixel at [i*PIX_W +: PIX_W]
//   layer_en    per-layer enable (0 = layer always transparent)
//   layer_win   per-layer window gate at this pixel position
//   prio_sel    slot s layer index at [s*IDX_W +: IDX_W]; slot 0 is topmost
//   border_in   colour used when no layer is visible
//   hires       1 = pack {previous nibble, current nibble} into the output
//   plex_out    mixed pixel, or packed hi-res pair
//   plex_valid  plex_out came from a valid input strobe
//
// Latency: inputs sampled at strobe k appear on plex_out after strobe k+2.

module video_plex_mixer #(
  parameter int NUM_LAYERS = 3,
  parameter int PIX_W      = 8,
  parameter int TRANSP_W   = 4,
  parameter int IDX_W      = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        c1,
  input  logic                        pix_valid,
  input  logic [NUM_LAYERS*PIX_W-1:0] layer_pix,
  input  logic [NUM_LAYERS-1:0]       layer_en,
  input  logic [NUM_LAYERS-1:0]       layer_win,
  input  logic [NUM_LAYERS*IDX_W-1:0] prio_sel,
  input  logic [PIX_W-1:0]            border_in,
  input  logic                        hires,
  output logic [PIX_W-1:0]            plex_out,
  output logic                        plex_valid
);

  // Stage 0 registers
  logic [NUM_LAYERS*PIX_W-1:0] s0_pix;
  logic [NUM_LAYERS-1:0]       s0_vis;
  logic [PIX_W-1:0]            s0_border;
  logic                        s0_hires;
  logic                        s0_valid;

  // Stage 1 registers
  logic [PIX_W-1:0]            s1_mix;
  logic                        s1_hires;
  logic                        s1_valid;

  // Nibble carried between consecutive pixels for hi-res packing
  logic [3:0]                  hold;

  logic [NUM_LAYERS-1:0]       vis_d;
  logic [PIX_W-1:0]            mix_d;
  logic                        hit;
  logic [PIX_W-1:0]            pair_d;
  logic [PIX_W-1:0]            out_d;

  // A layer is visible when it is enabled, inside its window, and its low
  // TRANSP_W bits are not all zero.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
    vis_d = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      vis_d[i] = layer_en[i] & layer_win[i] & (|layer_pix[i*PIX_W +: TRANSP_W]);
    end
  end

  // Priority scan. Slots are checked from topmost down, and the first visible
  // layer wins. A slot index >= NUM_LAYERS matches no layer, so that slot is
  // skipped. prio_sel is sampled here, at stage 1.
  always_comb begin
    mix_d = s0_border;
    hit   = 1'b0;
    for (int s = 0; s < NUM_LAYERS; s++) begin
      for (int l = 0; l < NUM_LAYERS; l++) begin
        if (!hit && prio_sel[s*IDX_W +: IDX_W] == IDX_W'(l) && s0_vis[l]) begin
          mix_d = s0_pix[l*PIX_W +: PIX_W];
          hit   = 1'b1;
        end
      end
    end
  end

  // Output formatting. The hires flag comes from stage 0, so a mode change
  // lines up with the pixel that was sampled together with it.
  always_comb begin
    pair_d = PIX_W'({hold, s1_mix[3:0]});
    out_d  = s1_hires ? pair_d : s1_mix;
  end

  always_ff @(posedge clk) begin
    // NOTE: the reset clears every pipeline stage and its valid bit, so no stale pixel is marked valid after reset.
    if (rst) begin
      s0_pix     <= '0;
      s0_vis     <= '0;
      s0_border  <= '0;
      s0_hires   <= 1'b0;
      s0_valid   <= 1'b0;
      s1_mix     <= '0;
      s1_hires   <= 1'b0;
      s1_valid   <= 1'b0;
      hold       <= '0;
      plex_out   <= '0;
      plex_valid <= 1'b0;
    end else if (c1) begin
      // NOTE: non-blocking assignments make each stage read the previous stage's old value, which forms a true pipeline.
      s0_pix     <= layer_pix;
      s0_vis     <= vis_d;
      s0_border  <= border_in;
      s0_hires   <= hires;
      s0_valid   <= pix_valid;
      s1_mix     <= mix_d;
      s1_hires   <= s0_hires;
      s1_valid   <= s0_valid;
      // hold updates in both modes, so switching into hi-res uses the true previous pixel.
      hold       <= s1_mix[3:0];
      plex_out   <= out_d;
      plex_valid <= s1_valid;
    end
  end

endmodule
